// File: rtl/rgb2yuv_arbiter.sv
// rtl/rgb2yuv_arbiter.sv - round-robin arbiter/sequencer sharing one RGB-to-YUV converter
//
// Grants one pixel requester at a time (round robin from the last grant), latches its
// R/G/B onto the converter, pulses conv_start, waits for conv_done under a watchdog and
// returns Y/U/V with a one-cycle one-hot ack.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req                        per-requester request level
//   req_r/req_g/req_b          packed operands, requester i at [i*BITS +: BITS]
//   ack, err                   one-hot completion pulse, timeout flag (held until next ack)
//   res_y/res_u/res_v, res_id  result and requester index, held until next ack
//   busy                       high in every state except IDLE
//   conv_start                 one-cycle start pulse to the converter
//   conv_r/conv_g/conv_b       converter operands, stable from ISSUE through RESP
//   conv_done, conv_y/u/v      converter completion and results
module rgb2yuv_arbiter #(
   parameter int BITS    = 9,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*BITS-1:0]    req_r,
   input  logic [NREQ*BITS-1:0]    req_g,
   input  logic [NREQ*BITS-1:0]    req_b,
   output logic [NREQ-1:0]         ack,
   output logic                    err,
   output logic [BITS-1:0]         res_y,
   output logic [BITS-1:0]         res_u,
   output logic [BITS-1:0]         res_v,
   output logic [$clog2(NREQ)-1:0] res_id,
   output logic                    busy,
   output logic                    conv_start,
   output logic [BITS-1:0]         conv_r,
   output logic [BITS-1:0]         conv_g,
   output logic [BITS-1:0]         conv_b,
   input  logic                    conv_done,
   input  logic [BITS-1:0]         conv_y,
   input  logic [BITS-1:0]         conv_u,
   input  logic [BITS-1:0]         conv_v
);

   localparam int IDW = $clog2(NREQ);
   localparam int CW  = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t         state;
   logic [CW-1:0]  cnt;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] gnt_id;
   logic [IDW-1:0] pick;
   logic [BITS-1:0] sel_r, sel_g, sel_b;

   // Round-robin pick: scan offsets from the far end down so the nearest
   // asserted index after last_grant is the one that sticks.
   always_comb begin
      pick = '0;
      for (int j = NREQ; j >= 1; j--) begin
         if (req[(int'(last_grant) + j) % NREQ]) begin
            pick = IDW'((int'(last_grant) + j) % NREQ);
         end
      end
      sel_r = req_r[int'(pick)*BITS +: BITS];
      sel_g = req_g[int'(pick)*BITS +: BITS];
      sel_b = req_b[int'(pick)*BITS +: BITS];
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         last_grant <= ID_LAST;
         gnt_id     <= '0;
         ack        <= '0;
         err        <= 1'b0;
         res_y      <= '0;
         res_u      <= '0;
         res_v      <= '0;
         res_id     <= '0;
         conv_start <= 1'b0;
         conv_r     <= '0;
         conv_g     <= '0;
         conv_b     <= '0;
      end else begin
         conv_start <= 1'b0;
         ack        <= '0;
         case (state)
            IDLE: begin
               if (|req) begin
                  gnt_id     <= pick;
                  conv_r     <= sel_r;
                  conv_g     <= sel_g;
                  conv_b     <= sel_b;
                  conv_start <= 1'b1;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= '0;
               state <= WAIT;
            end
            WAIT: begin
               // done is checked first so it wins over the final watchdog count
               if (conv_done) begin
                  res_y  <= conv_y;
                  res_u  <= conv_u;
                  res_v  <= conv_v;
                  err    <= 1'b0;
                  res_id <= gnt_id;
                  ack    <= NREQ'(1) << gnt_id;
                  state  <= RESP;
               end else if (cnt == CNT_LAST) begin
                  res_y  <= '0;
                  res_u  <= '0;
                  res_v  <= '0;
                  err    <= 1'b1;
                  res_id <= gnt_id;
                  ack    <= NREQ'(1) << gnt_id;
                  state  <= RESP;
               end else if (cnt != '1) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               last_grant <= gnt_id;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
